// File: rtl/nms_addr_seq.sv
// 3x3 non-maximum-suppression address sequencer: issues nine score reads around a
// centre pixel and reports whether the centre strictly dominates. Optional macro: NMS_BORDER_CHECK_EN.
module nms_addr_seq #(
    parameter int COLUMNS = 180,
    parameter int ROWS    = 120,
    parameter int ADDR_W  = 15,
    parameter int ROW_W   = 7,
    parameter int COL_W   = 8,
    parameter int SCORE_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ROW_W-1:0]   refRow,
    input  logic [COL_W-1:0]   refCol,
    output logic               scoreRd,
    output logic [ADDR_W-1:0]  scoreAddr,
    input  logic [SCORE_W-1:0] scoreData,
    output logic               busy,
    output logic               done,
    output logic               isMax
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLUMNS);
    localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);

    state_t              r_state;
    logic [3:0]          r_k;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_rd;
    logic                r_busy;
    logic                r_done;
    logic                r_ismax;
    logic                r_vld;
    logic [3:0]          r_vk;
    logic [SCORE_W-1:0]  r_center;
    logic                r_gt;

    logic [ADDR_W-1:0]   w_c;
    logic                w_border;
    logic                w_nb_hit;
    logic [3:0]          w_k_next;

    // Clockwise neighbour walk starting north of the centre; all arithmetic wraps.
    function automatic logic [ADDR_W-1:0] f_offset(input logic [3:0] k);
        case (k)
            4'd0:    f_offset = '0;
            4'd1:    f_offset = '0 - COLS_A;
            4'd2:    f_offset = ONE_A - COLS_A;
            4'd3:    f_offset = ONE_A;
            4'd4:    f_offset = COLS_A + ONE_A;
            4'd5:    f_offset = COLS_A;
            4'd6:    f_offset = COLS_A - ONE_A;
            4'd7:    f_offset = '0 - ONE_A;
            default: f_offset = '0 - COLS_A - ONE_A;
        endcase
    endfunction

    assign w_c      = ADDR_W'(32'(refRow) * 32'(COLUMNS) + 32'(refCol));
    assign w_k_next = r_k + 4'd1;

`ifdef NMS_BORDER_CHECK_EN
    assign w_border = (refRow == '0) || (refRow == ROW_W'(ROWS - 1)) ||
                      (refCol == '0) || (refCol == COL_W'(COLUMNS - 1));
`else
    assign w_border = 1'b0;
`endif

    // A neighbour equal to the centre also disqualifies it (ties are not maxima).
    assign w_nb_hit = r_vld && (r_vk != 4'd0) && (scoreData >= r_center);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_k      <= '0;
            r_base   <= '0;
            r_addr   <= '0;
            r_rd     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ismax  <= 1'b0;
            r_vld    <= 1'b0;
            r_vk     <= '0;
            r_center <= '0;
            r_gt     <= 1'b0;
        end else begin
            r_vld <= r_rd;
            r_vk  <= r_k;
            if (r_vld) begin
                if (r_vk == 4'd0)
                    r_center <= scoreData;
                else if (w_nb_hit)
                    r_gt <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy  <= 1'b1;
                        r_ismax <= 1'b0;
                        r_base  <= w_c;
                        r_k     <= '0;
                        if (w_border) begin
                            r_gt    <= 1'b0;
                            r_state <= S_DRAIN;
                        end else begin
                            r_gt    <= 1'b1;
                            r_rd    <= 1'b1;
                            r_addr  <= w_c;
                            r_state <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (r_k == 4'd8) begin
                        r_rd    <= 1'b0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_k    <= w_k_next;
                        r_addr <= r_base + f_offset(w_k_next);
                    end
                end
                S_DRAIN: begin
                    // Last neighbour's data arrives this cycle, so fold it in directly.
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_ismax <= r_gt && !w_nb_hit && (r_center != '0);
                    r_state <= S_DONE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign scoreRd   = r_rd;
    assign scoreAddr = r_addr;
    assign busy      = r_busy;
    assign done      = r_done;
    assign isMax     = r_ismax;

endmodule
